// File: rtl/pipe_pkg.sv
// Shared types and constants for pipeline stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } pipe_state_t;

  localparam int unsigned OCC_W = 2;

  // Number of beats held in a given state.
  function automatic logic [OCC_W-1:0] state_occ(input pipe_state_t s);
    logic [OCC_W-1:0] occ;
    occ = '0;
    case (s)
      ONE:     occ = 2'd1;
      TWO:     occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // Count up to all-ones and stick there until cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Stage register with valid/ready handshake, 2-entry skid buffer, stall,
// flush and a saturating stall-cycle counter.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W    = 32,
  parameter int unsigned        CNT_W     = 16,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stall_cycles
);

  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire, out_fire;
  logic              stall_inc;

  // Handshake outputs; the rst term keeps both low while reset is asserted.
  always_comb begin
    in_ready  = rst && !flush && !stall && (state_q != TWO);
    out_valid = rst && !flush && !stall && (state_q != EMPTY);
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    out_data  = main_q;
    occupancy = state_occ(state_q);
    stall_inc = stall && !flush && (state_q != EMPTY);
  end

  // Next-state and data path; stall needs no branch since it blocks both fires.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = TWO;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and payload registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .clr   (stat_clr),
    .count (stall_cycles)
  );

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised successor to the fixed-field stage registers between the execute and memory/writeback stages.
- Carries one opaque payload of DATA_W bits, which the caller packs from Addr, ALUResult, rdata2, SrcA, ImmExt, waddr and similar fields.
- Adds a valid/ready handshake with a 2-entry skid buffer, so back-pressure never drops a beat, plus stall, flush and a saturating stall-cycle counter for performance debug.
- Instantiated once per stage boundary in the pipelined core.

Parameters:
- DATA_W, 32: payload width in bits; must be at least 1.
- CNT_W, 16: stall-cycle counter width; must be at least 1.
- RESET_VAL, '0: value loaded into the payload registers on reset and on flush.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset. Assertion clears state immediately; release is synchronised externally.
- stall  in  1  freezes the stage: contents held, both handshakes blocked.
- flush  in  1  discards all held beats; takes priority over stall.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  beat presented downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  downstream payload, always taken from the main register.
- occupancy  out  2  number of held beats, 0 to 2.
- stat_clr  in  1  synchronous clear of stall_cycles.
- stall_cycles  out  CNT_W  saturating count of stalled, non-empty cycles.

Behaviour:
- Reset (rst=0, asynchronous):
  - state goes to EMPTY.
  - main and skid registers load RESET_VAL.
  - stall_cycles goes to 0.
  - Outputs during reset: out_valid=0, in_ready=0, occupancy=0.
- Combinational outputs:
  - in_ready = !flush && !stall && state!=TWO. It depends only on state and control inputs, never on out_ready.
  - out_valid = !flush && !stall && state!=EMPTY.
- Fire signals: in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
- States: EMPTY (occupancy 0), ONE (main valid, occupancy 1), TWO (main and skid valid, occupancy 2).
- EMPTY:
  - in_fire: main<=in_data, next state ONE.
- ONE:
  - in_fire and out_fire: main<=in_data, stay in ONE.
  - in_fire only: skid<=in_data, next state TWO.
  - out_fire only: next state EMPTY.
  - neither: hold.
- TWO:
  - No accept is possible (in_ready=0).
  - out_fire: main<=skid, next state ONE.
- Latency: a beat accepted into EMPTY appears on out_data/out_valid on the next cycle. Throughput is 1 beat per cycle when out_ready is held high.
- Stall (with flush=0):
  - No state or data change; out_data is held stable.
  - The reset-path behaviour of the original stage registers is preserved.
- Flush:
  - Next state is EMPTY; main and skid load RESET_VAL.
  - Overrides stall and any concurrent in_valid; no beat is accepted or emitted in the flush cycle.
- stall_cycles:
  - Increments when stall && !flush && state!=EMPTY.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - stat_clr forces it to 0 and wins over a simultaneous increment.
  - Flush does not clear it.
- Ordering: beats leave in arrival order; the skid beat always exits after the main beat.
- Reset mid-transfer: all held beats are lost; upstream must re-issue them.

Decomposition:
- Shared package pipe_pkg holds:
  - typedef enum logic [1:0] pipe_state_t {EMPTY, ONE, TWO}.
  - the occupancy width constant.
- One sub-module, sat_counter (parameters W; ports inc, clr), implements stall_cycles and can be reused by other stage instances.

Test Plan:
- Reset then release; drive in_valid=1, in_data=0xDEADBEEF, out_ready=1 -> out_valid=1 with 0xDEADBEEF one cycle later; in_ready stays 1; occupancy=1.
- Stream 0x1..0x8 with out_ready=0 from cycle 2 -> occupancy reaches 2 and in_ready=0. Release out_ready -> 0x1..0x8 arrive in order, none lost or duplicated.
- In state TWO holding 0xA and 0xB, assert stall for 5 cycles -> out_valid=0, in_ready=0, data held, stall_cycles=5. Deassert stall -> 0xA then 0xB emitted.
- Hold 0x55 and assert flush together with stall and in_valid (data 0x66) -> next cycle occupancy=0, out_valid=0, 0x66 never appears.
- With CNT_W=3, stall non-empty for 10 cycles -> stall_cycles saturates at 7. stat_clr together with stall -> 0.
- Drop rst asynchronously mid-clock while in TWO -> outputs go to 0 immediately, before the next clk edge.
